// File: rtl/edge_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_monitor: synchronizes and glitch-filters an async level, emitting a  |
// | clean level, rise/fall strobes, saturating edge and glitch counters.     |
// | Optional pulse-width measurement: define EDGE_MONITOR_PULSE_WIDTH_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8,
    parameter int WIDTH_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               clr_counts,
    output logic               out,
    output logic               rise,
    output logic               fall,
    output logic [CNT_W-1:0]   edge_count,
    output logic [CNT_W-1:0]   glitch_count
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
    ,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic               width_valid
`endif
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        P_HIGH = 2'd1,
        S_HIGH = 2'd2,
        P_LOW  = 2'd3
    } state_t;

    localparam logic [3:0] c_run_last = 4'(FILTER_LEN - 1);
    localparam bit         c_single   = (FILTER_LEN == 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("edge_monitor: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("edge_monitor: FILTER_LEN must be 1..15");
    end
    if (CNT_W < 1 || WIDTH_W < 1) begin : g_bad_widths
        $error("edge_monitor: CNT_W and WIDTH_W must be positive");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_run;
    logic [3:0]             w_run_next;
    logic                   w_commit_rise;
    logic                   w_commit_fall;
    logic                   w_glitch;
    logic                   r_out;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_edge_count;
    logic [CNT_W-1:0]       r_glitch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // The run counter holds how many samples of the pending level were seen.
    always_comb begin
        w_state_next  = r_state;
        w_run_next    = r_run;
        w_commit_rise = 1'b0;
        w_commit_fall = 1'b0;
        w_glitch      = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    if (c_single) begin
                        w_state_next  = S_HIGH;
                        w_commit_rise = 1'b1;
                    end else begin
                        w_state_next = P_HIGH;
                        w_run_next   = 4'd1;
                    end
                end
            end
            P_HIGH: begin
                if (!w_s) begin
                    w_state_next = S_LOW;
                    w_run_next   = 4'd0;
                    w_glitch     = 1'b1;
                end else if (r_run == c_run_last) begin
                    w_state_next  = S_HIGH;
                    w_run_next    = 4'd0;
                    w_commit_rise = 1'b1;
                end else begin
                    w_run_next = r_run + 4'd1;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    if (c_single) begin
                        w_state_next  = S_LOW;
                        w_commit_fall = 1'b1;
                    end else begin
                        w_state_next = P_LOW;
                        w_run_next   = 4'd1;
                    end
                end
            end
            P_LOW: begin
                if (w_s) begin
                    w_state_next = S_HIGH;
                    w_run_next   = 4'd0;
                    w_glitch     = 1'b1;
                end else if (r_run == c_run_last) begin
                    w_state_next  = S_LOW;
                    w_run_next    = 4'd0;
                    w_commit_fall = 1'b1;
                end else begin
                    w_run_next = r_run + 4'd1;
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_run_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOW;
            r_run   <= 4'd0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= w_run_next;
            r_rise  <= w_commit_rise;
            r_fall  <= w_commit_fall;
            if (w_commit_rise) begin
                r_out <= 1'b1;
            end else if (w_commit_fall) begin
                r_out <= 1'b0;
            end
        end
    end

    // Clear has priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk) begin
        if (reset || clr_counts) begin
            r_edge_count   <= '0;
            r_glitch_count <= '0;
        end else begin
            if ((w_commit_rise || w_commit_fall) && !(&r_edge_count)) begin
                r_edge_count <= r_edge_count + 1'b1;
            end
            if (w_glitch && !(&r_glitch_count)) begin
                r_glitch_count <= r_glitch_count + 1'b1;
            end
        end
    end

    assign out          = r_out;
    assign rise         = r_rise;
    assign fall         = r_fall;
    assign edge_count   = r_edge_count;
    assign glitch_count = r_glitch_count;

`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
    logic [WIDTH_W-1:0] r_hcnt;
    logic [WIDTH_W-1:0] r_pulse_width;
    logic               r_width_valid;

    // The fall commit captures the count before any further increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt        <= '0;
            r_pulse_width <= '0;
            r_width_valid <= 1'b0;
        end else begin
            r_width_valid <= w_commit_fall;
            if (w_commit_fall) begin
                r_pulse_width <= r_hcnt;
            end
            if (w_commit_rise) begin
                r_hcnt <= WIDTH_W'(1);
            end else if ((r_state == S_HIGH || r_state == P_LOW) && !(&r_hcnt)) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign pulse_width = r_pulse_width;
    assign width_valid = r_width_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_edge_monitor: scoreboard bench for edge_monitor with a run-length     |
// | reference model; directed scenarios followed by random stimulus.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_edge_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
    localparam int CNT_W       = 3;
    localparam int WIDTH_W     = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int WIDTH_MAX   = (1 << WIDTH_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in = 1'b0;
    logic               clr_counts = 1'b0;
    logic               out;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   edge_count;
    logic [CNT_W-1:0]   glitch_count;
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
    logic [WIDTH_W-1:0] pulse_width;
    logic               width_valid;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    edge_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_W       (CNT_W),
        .WIDTH_W     (WIDTH_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .clr_counts   (clr_counts),
        .out          (out),
        .rise         (rise),
        .fall         (fall),
        .edge_count   (edge_count),
        .glitch_count (glitch_count)
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
        ,
        .pulse_width  (pulse_width),
        .width_valid  (width_valid)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the level is accepted once FILTER_LEN consecutive
    // synchronized samples differ from the current output.
    typedef struct {
        bit is_rise;
        int edges;
        int glitches;
        int pw;
    } ev_t;

    ev_t evq[$];
    bit  hist[SYNC_STAGES];
    int  m_out = 0, m_cur = 0, m_run = 0, m_edges = 0, m_glitches = 0;
    int  m_hcnt = 0, m_pw = 0;

    always @(posedge clk) begin
        int  s;
        bit  rc, fc, gl;
        int  prev_out;
        ev_t e;
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) hist[k] = 1'b0;
            m_out = 0; m_cur = 0; m_run = 0; m_edges = 0; m_glitches = 0;
            m_hcnt = 0; m_pw = 0;
        end else begin
            s = int'(hist[SYNC_STAGES-1]);
            for (int k = SYNC_STAGES - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in;
            rc = 0; fc = 0; gl = 0;
            prev_out = m_out;
            if (s == m_cur) begin
                m_run++;
            end else begin
                if (m_cur != m_out) gl = 1;
                m_cur = s;
                m_run = 1;
            end
            if (m_cur != m_out && m_run == FILTER_LEN) begin
                rc = (m_cur == 1);
                fc = (m_cur == 0);
                m_out = m_cur;
            end
            if (clr_counts) begin
                m_edges = 0;
                m_glitches = 0;
            end else begin
                if ((rc || fc) && m_edges < CNT_MAX) m_edges++;
                if (gl && m_glitches < CNT_MAX) m_glitches++;
            end
            if (fc) m_pw = m_hcnt;
            else if (prev_out == 1 && m_hcnt < WIDTH_MAX) m_hcnt++;
            if (rc) m_hcnt = 1;
            if (rc || fc) begin
                e.is_rise = rc; e.edges = m_edges; e.glitches = m_glitches; e.pw = m_pw;
                evq.push_back(e);
            end
        end
    end

    int n_rise = 0;
    int n_fall = 0;
    int last_pw = 0;

    // Monitor: pops an expected event whenever the DUT shows a strobe.
    always @(negedge clk) begin
        ev_t e;
        check("out", out, m_out);
        check("edge_count", edge_count, m_edges);
        check("glitch_count", glitch_count, m_glitches);
        check("rise_and_fall", rise & fall, 0);
        if (rise) n_rise++;
        if (fall) n_fall++;
        if (rise || fall) begin
            if (evq.size() == 0) begin
                check("unexpected_strobe", {rise, fall}, 2'b00);
            end else begin
                e = evq.pop_front();
                check("ev_rise", rise, e.is_rise);
                check("ev_fall", fall, !e.is_rise);
                check("ev_edge_count", edge_count, e.edges);
                check("ev_glitch_count", glitch_count, e.glitches);
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
                if (!e.is_rise) begin
                    check("ev_width_valid", width_valid, 1);
                    check("ev_pulse_width", pulse_width, e.pw);
                end
`endif
            end
        end else if (evq.size() != 0) begin
            e = evq.pop_front();
            check("missing_strobe", {rise, fall}, e.is_rise ? 2'b10 : 2'b01);
        end
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
        check("pulse_width", pulse_width, m_pw);
        if (!fall) check("width_valid_idle", width_valid, 0);
        if (width_valid) last_pw = int'(pulse_width);
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int hi;
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        tick(50);
        check("idle_out", out, 0);
        check("idle_edges", edge_count, 0);
        check("idle_glitches", glitch_count, 0);
        check("idle_strobes", n_rise + n_fall, 0);

        // Clean rise and its latency
        in = 1'b1;
        measure_latency(lat);
        check("rise_latency", lat, SYNC_STAGES + FILTER_LEN);
        check("rise_strobe", rise, 1);
        @(posedge clk);
        #1;
        check("rise_one_cycle", rise, 0);
        check("rise_edges", edge_count, 1);

        // Short pulses are rejected
        @(negedge clk);
        in = 1'b0;
        tick(10);
        clr_counts = 1'b1;
        tick(1);
        clr_counts = 1'b0;
        for (int p = 0; p < 4; p++) begin
            in = 1'b1;
            tick(2);
            in = 1'b0;
            tick(8);
        end
        check("glitch_out", out, 0);
        check("glitch_count4", glitch_count, 4);
        check("glitch_edges", edge_count, 0);

        // 20-cycle pulse
        in = 1'b1;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 19) in = 1'b0;
            if (out) hi++;
        end
        check("pulse_high_cycles", hi, 20);
        check("pulse_edges", edge_count, 2);
`ifdef EDGE_MONITOR_PULSE_WIDTH_EN
        check("pulse_width_20", last_pw, 20);
`endif

        // Saturation, then clear in the cycle of a commit
        clr_counts = 1'b1;
        tick(1);
        clr_counts = 1'b0;
        for (int t = 0; t < 9; t++) begin
            in = ~in;
            tick(10);
        end
        check("sat_edges", edge_count, CNT_MAX);
        in = ~in;
        tick(5);
        clr_counts = 1'b1;
        tick(1);
        clr_counts = 1'b0;
        check("clr_wins_edges", edge_count, 0);
        check("clr_commit_out", out, in);

        // Reset while pending high with run=2
        in = 1'b0;
        tick(12);
        in = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midpend_out", out, 0);
        check("midpend_edges", edge_count, 0);
        check("midpend_glitches", glitch_count, 0);
        measure_latency(lat);
        check("post_reset_latency", lat, SYNC_STAGES + FILTER_LEN);

        // Random stimulus
        @(negedge clk);
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            len = $urandom_range(1, 12);
            in = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                clr_counts = ($urandom_range(0, 39) == 0);
                reset = ($urandom_range(0, 599) == 0);
                @(negedge clk);
            end
        end
        clr_counts = 1'b0;
        reset = 1'b0;
        tick(20);
        check("queue_drained", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
